raifes_np_hasti_sram: RTL and testbench

Parametrised N-port AHB-Lite (HASTI) SRAM slave for core simulation and small SoC builds. It is the successor to the fixed dual-port test memory and serves instruction and data masters, plus optional extra masters such as a debug or DMA port, from one shared word array. Over the fixed dual-port version it adds:
- a configurable port count;
- programmable wait states;
- a two-cycle ERROR response for illegal transfers;
- defined same-cycle write collision and read-after-write bypass rules.

---
 rtl/raifes_np_hasti_sram_if.sv | 27 ++
 rtl/raifes_np_hasti_sram.sv | 195 +++++++++++++++++++
 tb/tb_raifes_np_hasti_sram.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/raifes_np_hasti_sram_if.sv
// N-port AHB-Lite (HASTI) bundle: one packed lane per port, shared by the
// SRAM slave and whatever masters drive it.
interface raifes_np_hasti_sram_if #(
    parameter int N_PORTS = 2
);
    logic [N_PORTS-1:0][31:0] haddr;
    logic [N_PORTS-1:0]       hwrite;
    logic [N_PORTS-1:0][2:0]  hsize;
    logic [N_PORTS-1:0][2:0]  hburst;
    logic [N_PORTS-1:0]       hmastlock;
    logic [N_PORTS-1:0][3:0]  hprot;
    logic [N_PORTS-1:0][1:0]  htrans;
    logic [N_PORTS-1:0][31:0] hwdata;
    logic [N_PORTS-1:0][31:0] hrdata;
    logic [N_PORTS-1:0]       hready;
    logic [N_PORTS-1:0]       hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/raifes_np_hasti_sram.sv
// N-port AHB-Lite SRAM slave: one FSM per port in front of a shared word array,
// with same-edge write merging (port 0 wins) and read-after-write bypass.
module raifes_np_hasti_sram_port #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter bit          ERR_ENABLE  = 1'b1,
    parameter int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [31:0]   i_haddr,
    input  logic          i_hwrite,
    input  logic [2:0]    i_hsize,
    input  logic [1:0]    i_htrans,
    output logic          o_hready,
    output logic          o_hresp,
    output logic          o_we,
    output logic          o_rd,
    output logic [AW-1:0] o_idx,
    output logic [3:0]    o_be
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_be;
    logic          r_write;
    logic          r_hready;
    logic          r_hresp;

    logic [31:0]   w_off;
    logic          w_accept;
    logic          w_legal;
    logic [3:0]    w_be;

    // Offset wraps below BASE_ADDR, so one unsigned compare covers both bounds.
    assign w_off    = i_haddr - BASE_ADDR;
    assign w_accept = ((i_htrans == 2'd2) || (i_htrans == 2'd3)) && r_hready;
    assign w_legal  = !ERR_ENABLE ||
                      (({1'b0, w_off} < SPAN) && (i_hsize <= 3'd2) &&
                       !((i_hsize == 3'd1) && i_haddr[0]) &&
                       !((i_hsize == 3'd2) && (i_haddr[1:0] != 2'd0)));

    always_comb begin
        case (i_hsize)
            3'd0:    w_be = 4'b0001 << i_haddr[1:0];
            3'd1:    w_be = 4'b0011 << i_haddr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_be     <= '0;
            r_write  <= 1'b0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all share the accept-address rules.
                    if (w_accept) begin
                        r_idx   <= w_off[AW+1:2];
                        r_be    <= w_be;
                        r_write <= i_hwrite;
                        if (!w_legal) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state  <= S_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end else begin
                            r_state  <= S_WAIT;
                            r_cnt    <= 4'(WAIT_STATES - 1);
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_hready = r_hready;
    assign o_hresp  = r_hresp;
    assign o_we     = (r_state == S_DATA) && r_write;
    assign o_rd     = (r_state == S_DATA) && !r_write;
    assign o_idx    = r_idx;
    assign o_be     = r_be;
endmodule

module raifes_np_hasti_sram #(
    parameter int          N_PORTS     = 2,
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter bit          ERR_ENABLE  = 1'b1
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    raifes_np_hasti_sram_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [N_PORTS-1:0]          w_we;
    logic [N_PORTS-1:0]          w_rd;
    logic [N_PORTS-1:0][AW-1:0]  w_idx;
    logic [N_PORTS-1:0][3:0]     w_be;
    logic [N_PORTS-1:0]          w_hready;
    logic [N_PORTS-1:0]          w_hresp;
    logic [N_PORTS-1:0][31:0]    w_rdata;
    logic [31:0]                 w_word;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        raifes_np_hasti_sram_port #(
            .DEPTH_WORDS (DEPTH_WORDS),
            .BASE_ADDR   (BASE_ADDR),
            .WAIT_STATES (WAIT_STATES),
            .ERR_ENABLE  (ERR_ENABLE),
            .AW          (AW)
        ) u_port (
            .hclk     (hclk),
            .hresetn  (hresetn),
            .i_haddr  (bus.haddr[g]),
            .i_hwrite (bus.hwrite[g]),
            .i_hsize  (bus.hsize[g]),
            .i_htrans (bus.htrans[g]),
            .o_hready (w_hready[g]),
            .o_hresp  (w_hresp[g]),
            .o_we     (w_we[g]),
            .o_rd     (w_rd[g]),
            .o_idx    (w_idx[g]),
            .o_be     (w_be[g])
        );
    end

    // Descending port order: the last assignment (port 0) owns overlapping bytes.
    always_ff @(posedge hclk) begin
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            for (int b = 0; b < 4; b++) begin
                if (w_we[p] && w_be[p][b])
                    r_mem[w_idx[p]][8*b +: 8] <= bus.hwdata[p][8*b +: 8];
            end
        end
    end

    // Read bypass applies the same-edge writes with the same priority as the array.
    always_comb begin
        w_rdata = '0;
        w_word  = '0;
        for (int g = 0; g < N_PORTS; g++) begin
            w_word = r_mem[w_idx[g]];
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_we[p] && w_be[p][b] && (w_idx[p] == w_idx[g]))
                        w_word[8*b +: 8] = bus.hwdata[p][8*b +: 8];
                end
            end
            if (w_rd[g])
                w_rdata[g] = w_word;
        end
    end

    assign bus.hrdata = w_rdata;
    assign bus.hready = w_hready;
    assign bus.hresp  = w_hresp;
endmodule

// File: tb/tb_raifes_np_hasti_sram.sv
// Bench: dut_a (W=0) gets directed + random traffic vs a word-array model;
// dut_b (W=2) covers wait-state timing and reset during a wait.
module tb_raifes_np_hasti_sram;
    localparam int NP    = 2;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic        v;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } tr_t;

    logic hclk = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;
    always #5 hclk = ~hclk;

    raifes_np_hasti_sram_if #(.N_PORTS(NP)) ba ();
    raifes_np_hasti_sram_if #(.N_PORTS(NP)) bb ();

    raifes_np_hasti_sram #(.N_PORTS(NP), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
        .WAIT_STATES(0), .ERR_ENABLE(1'b1)) dut_a (.hclk(hclk), .hresetn(rstn_a), .bus(ba));
    raifes_np_hasti_sram #(.N_PORTS(NP), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0),
        .WAIT_STATES(2), .ERR_ENABLE(1'b1)) dut_b (.hclk(hclk), .hresetn(rstn_b), .bus(bb));

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [DEPTH];
    tr_t         pend [NP];
    logic [31:0] obs_rd [NP];
    tr_t         NO;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic tr_t mk(input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
        tr_t t;
        t.v = 1'b1; t.wr = wr; t.sz = sz; t.a = a; t.d = d;
        return t;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] sz, input logic [1:0] lo);
        logic [3:0] one = 4'b0001;
        logic [3:0] two = 4'b0011;
        if (sz == 3'd0) return one << lo;
        if (sz == 3'd1) return two << lo;
        return 4'b1111;
    endfunction

    // Word as it looks once every pending write lands, port 0 last.
    function automatic logic [31:0] merged(input int idx);
        logic [31:0] w = mdl[idx];
        for (int p = NP - 1; p >= 0; p--) begin
            if (pend[p].v && pend[p].wr && (int'(pend[p].a[9:2]) == idx)) begin
                logic [3:0] be = be_of(pend[p].sz, pend[p].a[1:0]);
                for (int b = 0; b < 4; b++)
                    if (be[b]) w[8*b +: 8] = pend[p].d[8*b +: 8];
            end
        end
        return w;
    endfunction

    // One W=0 bus cycle on dut_a: issue t0/t1, check the previous beat's data phase.
    task automatic cycle(input tr_t t0, input tr_t t1);
        tr_t nt [NP];
        logic [31:0] exp;
        nt[0] = t0; nt[1] = t1;
        for (int p = 0; p < NP; p++) begin
            ba.htrans[p] = nt[p].v ? 2'd2 : 2'd0;
            ba.haddr[p]  = nt[p].a;
            ba.hwrite[p] = nt[p].wr;
            ba.hsize[p]  = nt[p].sz;
            ba.hwdata[p] = pend[p].d;
        end
        @(negedge hclk);
        for (int p = 0; p < NP; p++) begin
            exp = (pend[p].v && !pend[p].wr) ? merged(int'(pend[p].a[9:2])) : 32'h0;
            chk($sformatf("rdy%0d", p), 32'(ba.hready[p]), 32'h1);
            chk($sformatf("rsp%0d", p), 32'(ba.hresp[p]), 32'h0);
            chk($sformatf("rd%0d@%h", p, pend[p].a), ba.hrdata[p], exp);
            obs_rd[p] = ba.hrdata[p];
        end
        @(posedge hclk);
        for (int p = NP - 1; p >= 0; p--)
            if (pend[p].v && pend[p].wr) mdl[pend[p].a[9:2]] = merged(int'(pend[p].a[9:2]));
        for (int p = 0; p < NP; p++) pend[p] = nt[p];
        #1;
    endtask

    // Illegal transfer on dut_a port 0: ERR1, ERR2, then back to idle.
    task automatic err_test(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        ba.htrans[0] = 2'd2; ba.haddr[0] = a; ba.hwrite[0] = wr; ba.hsize[0] = sz;
        @(posedge hclk); #1;
        ba.htrans[0] = 2'd0; ba.hwdata[0] = 32'hFFFF_FFFF;
        @(negedge hclk);
        chk($sformatf("err1_rdy@%h", a), 32'(ba.hready[0]), 32'h0);
        chk($sformatf("err1_rsp@%h", a), 32'(ba.hresp[0]), 32'h1);
        chk($sformatf("err1_rd@%h", a), ba.hrdata[0], 32'h0);
        @(posedge hclk); #1;
        @(negedge hclk);
        chk($sformatf("err2_rdy@%h", a), 32'(ba.hready[0]), 32'h1);
        chk($sformatf("err2_rsp@%h", a), 32'(ba.hresp[0]), 32'h1);
        @(posedge hclk); #1;
        @(negedge hclk);
        chk($sformatf("erri_rsp@%h", a), 32'(ba.hresp[0]), 32'h0);
        @(posedge hclk); #1;
    endtask

    // Non-pipelined word transfer on dut_b; nlow counts hready-low cycles (bounded).
    task automatic b_xfer(input int p, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int nlow, output logic [31:0] rd);
        bb.haddr[p] = a; bb.hwrite[p] = wr; bb.hsize[p] = 3'd2; bb.htrans[p] = 2'd2;
        @(posedge hclk); #1;
        bb.htrans[p] = 2'd0; bb.hwdata[p] = wd;
        nlow = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge hclk);
            if (bb.hready[p]) break;
            nlow++;
        end
        rd = bb.hrdata[p];
        @(posedge hclk); #1;
    endtask

    function automatic tr_t rnd_tr();
        tr_t t;
        int  lane;
        t.v  = ($urandom_range(3) != 0);
        t.wr = 1'($urandom_range(1));
        t.sz = 3'($urandom_range(2));
        lane = (t.sz == 3'd0) ? $urandom_range(3) : (t.sz == 3'd1) ? 2 * $urandom_range(1) : 0;
        t.a  = 32'h200 + 32'($urandom_range(7) * 4 + lane);
        t.d  = $urandom;
        return t;
    endfunction

    initial begin
        int nl;
        logic [31:0] rd;
        NO = '0;
        pend[0] = '0; pend[1] = '0;
        ba.htrans = '0; ba.haddr = '0; ba.hwrite = '0; ba.hsize = '0; ba.hwdata = '0;
        ba.hburst = '0; ba.hmastlock = '0; ba.hprot = '0;
        bb.htrans = '0; bb.haddr = '0; bb.hwrite = '0; bb.hsize = '0; bb.hwdata = '0;
        bb.hburst = '0; bb.hmastlock = '0; bb.hprot = '0;

        #12;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rst_rdy%0d", p), 32'(ba.hready[p]), 32'h1);
            chk($sformatf("rst_rsp%0d", p), 32'(ba.hresp[p]), 32'h0);
            chk($sformatf("rst_rd%0d", p), ba.hrdata[p], 32'h0);
        end
        rstn_a = 1'b1; rstn_b = 1'b1;
        @(posedge hclk); #1;

        // sub-word writes, single-cycle read latency
        cycle(mk(1'b1, 3'd2, 32'h100, 32'h1122_3344), NO);
        cycle(mk(1'b1, 3'd0, 32'h102, 32'h00AA_0000), NO);
        cycle(mk(1'b1, 3'd1, 32'h100, 32'h0000_BEEF), NO);
        cycle(mk(1'b0, 3'd2, 32'h100, 32'h0), NO);
        cycle(NO, NO);
        chk("bh_rd", obs_rd[0], 32'h11AA_BEEF);

        // collision and bypass
        cycle(mk(1'b1, 3'd0, 32'h20, 32'h0000_00FF), mk(1'b1, 3'd2, 32'h20, 32'h1234_5678));
        cycle(mk(1'b0, 3'd2, 32'h20, 32'h0), NO);
        cycle(NO, NO);
        chk("coll", obs_rd[0], 32'h1234_56FF);
        cycle(mk(1'b1, 3'd2, 32'h30, 32'hCAFE_F00D), mk(1'b0, 3'd2, 32'h30, 32'h0));
        cycle(NO, NO);
        chk("bypass", obs_rd[1], 32'hCAFE_F00D);

        // error responses leave memory untouched
        cycle(mk(1'b1, 3'd2, 32'h4, 32'h4444_4444), NO);
        cycle(NO, NO);
        err_test(1'b0, 3'd2, 32'h2);
        err_test(1'b0, 3'd2, 32'h400);
        err_test(1'b1, 3'd2, 32'h6);
        err_test(1'b1, 3'd3, 32'h100);
        err_test(1'b1, 3'd1, 32'h101);
        cycle(mk(1'b0, 3'd2, 32'h4, 32'h0), mk(1'b0, 3'd2, 32'h100, 32'h0));
        cycle(NO, NO);
        chk("err_mem4", obs_rd[0], 32'h4444_4444);
        chk("err_mem100", obs_rd[1], 32'h11AA_BEEF);

        // randomized two-port traffic over eight shared words
        for (int i = 0; i < 8; i++)
            cycle(mk(1'b1, 3'd2, 32'h200 + 32'(4 * i), $urandom), NO);
        for (int i = 0; i < 300; i++)
            cycle(rnd_tr(), rnd_tr());
        cycle(NO, NO);

        // dut_b: wait states and pipelined SEQ in the data cycle
        b_xfer(0, 1'b1, 32'h8, 32'hA5A5_0008, nl, rd);
        chk("b_wlow", 32'(nl), 32'd2);
        b_xfer(0, 1'b1, 32'hC, 32'h5A5A_000C, nl, rd);
        bb.haddr[0] = 32'h8; bb.hwrite[0] = 1'b0; bb.hsize[0] = 3'd2; bb.htrans[0] = 2'd2;
        @(posedge hclk); #1;
        bb.htrans[0] = 2'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk);
            chk($sformatf("b_low8_%0d", k), 32'(bb.hready[0]), 32'h0);
            @(posedge hclk); #1;
        end
        bb.haddr[0] = 32'hC; bb.htrans[0] = 2'd3;
        @(negedge hclk);
        chk("b_rdy8", 32'(bb.hready[0]), 32'h1);
        chk("b_rd8", bb.hrdata[0], 32'hA5A5_0008);
        @(posedge hclk); #1;
        bb.htrans[0] = 2'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk);
            chk($sformatf("b_lowC_%0d", k), 32'(bb.hready[0]), 32'h0);
            @(posedge hclk); #1;
        end
        @(negedge hclk);
        chk("b_rdyC", 32'(bb.hready[0]), 32'h1);
        chk("b_rdC", bb.hrdata[0], 32'h5A5A_000C);
        @(posedge hclk); #1;

        // dut_b: reset in the middle of a port-1 wait discards the write
        b_xfer(1, 1'b1, 32'h40, 32'h0BAD_CAFE, nl, rd);
        bb.haddr[1] = 32'h40; bb.hwrite[1] = 1'b1; bb.hsize[1] = 3'd2; bb.htrans[1] = 2'd2;
        @(posedge hclk); #1;
        bb.htrans[1] = 2'd0; bb.hwdata[1] = 32'hDEAD_BEEF;
        @(negedge hclk);
        chk("rst_prewait", 32'(bb.hready[1]), 32'h0);
        #1 rstn_b = 1'b0;
        #1;
        chk("rstw_rdy", 32'(bb.hready[1]), 32'h1);
        chk("rstw_rsp", 32'(bb.hresp[1]), 32'h0);
        chk("rstw_rd", bb.hrdata[1], 32'h0);
        @(posedge hclk); @(posedge hclk); @(posedge hclk); #1;
        rstn_b = 1'b1;
        @(posedge hclk); #1;
        b_xfer(1, 1'b0, 32'h40, 32'h0, nl, rd);
        chk("rst_nlow", 32'(nl), 32'd2);
        chk("rst_old40", rd, 32'h0BAD_CAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
